// File: rtl/md5_pkg.sv
// Shared definitions for the MD5 block feeder: FSM encoding and padding constants.
package md5_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_PAD,
        ST_ISSUE,
        ST_WAIT_LO,
        ST_WAIT_HI
    } md5_state_t;

    localparam logic [7:0] MD5_PAD_BYTE    = 8'h80;
    localparam int         MD5_LEN_OFFSET  = 56;
    localparam int         MD5_BLOCK_BYTES = 64;

endpackage

// File: rtl/md5_block_feeder_pad_mask.sv
// Combinational padding overlay: which buffered bytes survive the PAD cycle
// and what replaces the rest (0x80 marker, zeros, little-endian bit length).
module md5_pad_mask
    import md5_pkg::*;
(
    input  logic [5:0]                 q,
    input  logic                       pend80,
    input  logic                       len_only,
    input  logic                       write_len,
    input  logic [63:0]                bit_len,
    output logic [MD5_BLOCK_BYTES-1:0] keep,
    output logic [0:511]               overlay
);

    always_comb begin
        keep    = '0;
        overlay = '0;
        for (int i = 0; i < MD5_BLOCK_BYTES; i++) begin
            if (!pend80 && !len_only && (i < int'(q)))
                keep[i] = 1'b1;
            if (write_len && (i >= MD5_LEN_OFFSET))
                overlay[8*i +: 8] = bit_len[8*(i-MD5_LEN_OFFSET) +: 8];
        end
        // A marker deferred from a full final block always lands at byte 0.
        if (pend80)
            overlay[0 +: 8] = MD5_PAD_BYTE;
        else if (!len_only)
            overlay[8*int'(q) +: 8] = MD5_PAD_BYTE;
    end

endmodule

// File: rtl/md5_block_feeder.sv
// Byte-stream front end for the MD5 core: pads messages and issues 512-bit blocks.
// Optional 16-bit issued-block counter output enabled by `define MD5_FEEDER_BLKCNT_EN.
module md5_block_feeder
    import md5_pkg::*;
#(
    parameter int CNT_W = 61
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_data,
    input  logic         in_last,
    output logic [0:511] core_block,
    output logic         core_start,
    output logic         core_resume,
    input  logic         core_done,
    output logic         msg_done
`ifdef MD5_FEEDER_BLKCNT_EN
    ,
    output logic [15:0]  blk_cnt
`endif
);

    md5_state_t state, next_state;

    logic [5:0]       ptr;
    logic [CNT_W-1:0] cnt;
    logic             first;
    logic             pend80;
    logic             pendlen;
    logic             is_final;
    logic             len_only;

    logic             accept;
    logic             enter;
    logic             done_final;
    logic             goto_len;
    logic             write_len;
    logic [63:0]      bit_len;
    logic [MD5_BLOCK_BYTES-1:0] keep;
    logic [0:511]     overlay;
    logic [0:511]     pad_block;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state  = state;
        in_ready    = 1'b0;
        core_start  = 1'b0;
        core_resume = 1'b0;
        accept      = 1'b0;
        enter       = 1'b0;
        done_final  = 1'b0;
        goto_len    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    enter      = 1'b1;
                    next_state = ST_FILL;
                end
            end
            ST_FILL: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept = 1'b1;
                    if (in_last)
                        next_state = (ptr == 6'd63) ? ST_ISSUE : ST_PAD;
                    else if (ptr == 6'd63)
                        next_state = ST_ISSUE;
                end
            end
            ST_PAD: next_state = ST_ISSUE;
            ST_ISSUE: begin
                core_start  = first;
                core_resume = !first;
                next_state  = ST_WAIT_LO;
            end
            // The core's done level from the previous block must drop first.
            ST_WAIT_LO: begin
                if (!core_done)
                    next_state = ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
                if (core_done) begin
                    if (is_final) begin
                        done_final = 1'b1;
                        next_state = ST_IDLE;
                    end else if (pendlen) begin
                        goto_len   = 1'b1;
                        next_state = ST_PAD;
                    end else begin
                        next_state = ST_FILL;
                    end
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    assign bit_len   = 64'({cnt, 3'b000});
    assign write_len = len_only || pend80 || (ptr <= 6'(MD5_LEN_OFFSET - 1));

    md5_pad_mask u_pad_mask (
        .q        (ptr),
        .pend80   (pend80),
        .len_only (len_only),
        .write_len(write_len),
        .bit_len  (bit_len),
        .keep     (keep),
        .overlay  (overlay)
    );

    always_comb begin
        pad_block = '0;
        for (int i = 0; i < MD5_BLOCK_BYTES; i++)
            pad_block[8*i +: 8] = keep[i] ? core_block[8*i +: 8] : overlay[8*i +: 8];
    end

    // Block buffer and message bookkeeping; the buffer is only written in FILL/PAD
    // and on the length-only hand-off, so it stays stable while the core reads it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            core_block <= '0;
            ptr        <= '0;
            cnt        <= '0;
            first      <= 1'b0;
            pend80     <= 1'b0;
            pendlen    <= 1'b0;
            is_final   <= 1'b0;
            len_only   <= 1'b0;
            msg_done   <= 1'b0;
        end else begin
            msg_done <= done_final;
            if (enter) begin
                ptr      <= '0;
                cnt      <= '0;
                first    <= 1'b1;
                pend80   <= 1'b0;
                pendlen  <= 1'b0;
                is_final <= 1'b0;
                len_only <= 1'b0;
            end
            if (accept) begin
                core_block[{ptr, 3'b000} +: 8] <= in_data;
                ptr <= ptr + 6'd1;
                cnt <= cnt + CNT_W'(1);
                if (in_last && (ptr == 6'd63)) begin
                    pend80  <= 1'b1;
                    pendlen <= 1'b1;
                end
            end
            if (state == ST_PAD) begin
                core_block <= pad_block;
                if (write_len) begin
                    pendlen  <= 1'b0;
                    is_final <= 1'b1;
                end else begin
                    pendlen  <= 1'b1;
                end
            end
            if (state == ST_ISSUE)
                first <= 1'b0;
            if (goto_len) begin
                core_block <= '0;
                ptr        <= '0;
                len_only   <= 1'b1;
            end
        end
    end

`ifdef MD5_FEEDER_BLKCNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            blk_cnt <= '0;
        else if (enter)
            blk_cnt <= '0;
        else if ((state == ST_ISSUE) && (blk_cnt != 16'hFFFF))
            blk_cnt <= blk_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_md5_block_feeder.sv
// Scoreboard bench for md5_block_feeder with a behavioural MD5-core handshake model.
module tb_md5_block_feeder;

    typedef logic [7:0] bytes_t[$];
    typedef struct {
        logic [0:511] blk;
        logic         start;
    } exp_t;

    localparam int CORE_LAT = 66;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [7:0]   in_data = 8'h00;
    logic         in_last = 1'b0;
    logic [0:511] core_block;
    logic         core_start;
    logic         core_resume;
    logic         core_done;
    logic         msg_done;
`ifdef MD5_FEEDER_BLKCNT_EN
    logic [15:0]  blk_cnt;
`endif

    int   checks = 0;
    int   failures = 0;
    int   cycle = 0;
    int   rise_cycle = -100;
    int   done_count = 0;
    int   msgs_done_exp = 0;
    int   last_blocks = 0;
    logic prev_done = 1'b0;
    logic prev_msg_done = 1'b0;
    logic busy = 1'b0;
    int   core_ctr = 0;
    exp_t exp_q[$];

    md5_block_feeder dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .core_block (core_block),
        .core_start (core_start),
        .core_resume(core_resume),
        .core_done  (core_done),
        .msg_done   (msg_done)
`ifdef MD5_FEEDER_BLKCNT_EN
        ,
        .blk_cnt    (blk_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Core handshake model: done drops after a start/resume and rises CORE_LAT later.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            core_done <= 1'b0;
            busy      <= 1'b0;
            core_ctr  <= 0;
        end else if (core_start || core_resume) begin
            core_done <= 1'b0;
            busy      <= 1'b1;
            core_ctr  <= 0;
        end else if (busy) begin
            if (core_ctr == CORE_LAT - 1) begin
                core_done <= 1'b1;
                busy      <= 1'b0;
            end
            core_ctr <= core_ctr + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Independent MD5 padding model: message, 0x80, zeros to 56 mod 64, 64-bit LE bit length.
    task automatic pushExpected(input bytes_t msg);
        bytes_t     padded;
        logic [63:0] bits;
        exp_t        e;
        padded = msg;
        padded.push_back(8'h80);
        while ((padded.size() % 64) != 56)
            padded.push_back(8'h00);
        bits = 64'(msg.size()) * 64'd8;
        for (int i = 0; i < 8; i++)
            padded.push_back(bits[8*i +: 8]);
        last_blocks = padded.size() / 64;
        for (int b = 0; b < padded.size() / 64; b++) begin
            e.blk = '0;
            for (int j = 0; j < 64; j++)
                e.blk[8*j +: 8] = padded[64*b + j];
            e.start = (b == 0);
            exp_q.push_back(e);
        end
    endtask

    task automatic sendByte(input logic [7:0] d, input logic last, output bit ok);
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok)
            checkOutput("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic applyStimulus(input bytes_t msg);
        bit ok;
        bit seen;
        pushExpected(msg);
        msgs_done_exp++;
        for (int i = 0; i < msg.size(); i++) begin
            sendByte(msg[i], i == msg.size() - 1, ok);
            if (!ok)
                return;
        end
        seen = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (msg_done) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("msg_done_seen", seen, 1);
        checkOutput("blocks_left", exp_q.size(), 0);
`ifdef MD5_FEEDER_BLKCNT_EN
        checkOutput("blk_cnt", blk_cnt, last_blocks);
`endif
    endtask

    // Output monitor: compares each issued block with the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        cycle++;
        if (!rst) begin
            if (core_start || core_resume) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_issue", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("block", core_block, e.blk);
                    checkOutput("issue_kind", {core_start, core_resume}, e.start ? 2'b10 : 2'b01);
                end
                checkOutput("in_ready_issue", in_ready, 0);
            end
            if (busy)
                checkOutput("in_ready_busy", in_ready, 0);
            if (core_done && !prev_done)
                rise_cycle = cycle;
            if (msg_done) begin
                done_count++;
                checkOutput("msg_done_latency", cycle - rise_cycle, 1);
                checkOutput("msg_done_width", prev_msg_done, 0);
            end
        end
        prev_done     = core_done;
        prev_msg_done = msg_done;
    end

    initial begin
        bytes_t m;
        bit     ok;

        repeat (2) @(negedge clk);
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_start", core_start, 0);
        checkOutput("rst_resume", core_resume, 0);
        checkOutput("rst_msg_done", msg_done, 0);
        checkOutput("rst_block", core_block, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        m = '{8'h61, 8'h62, 8'h63};
        applyStimulus(m);
        m = '{8'h61};
        applyStimulus(m);

        m = {};
        for (int i = 0; i < 55; i++) m.push_back(8'h61);
        applyStimulus(m);
        m.push_back(8'h61);
        applyStimulus(m);
        m = {};
        for (int i = 0; i < 64; i++) m.push_back(8'h61);
        applyStimulus(m);
        m = {};
        for (int i = 0; i < 119; i++) m.push_back(8'($urandom_range(0, 255)));
        applyStimulus(m);
        m = {};
        for (int i = 0; i < 200; i++) m.push_back(8'($urandom_range(0, 255)));
        applyStimulus(m);

        // Abort a 100-byte message at byte 30 with reset, then recover.
        for (int i = 0; i < 30; i++) begin
            sendByte(8'($urandom_range(0, 255)), 1'b0, ok);
            if (!ok) break;
        end
        rst = 1'b1;
        in_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        checkOutput("mid_rst_in_ready", in_ready, 0);
        checkOutput("mid_rst_start", core_start | core_resume, 0);
        checkOutput("mid_rst_msg_done", msg_done, 0);
        checkOutput("mid_rst_block", core_block, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        m = '{8'h61, 8'h62, 8'h63};
        applyStimulus(m);

        repeat (5) @(negedge clk);
        checkOutput("msg_done_count", done_count, msgs_done_exp);
        checkOutput("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: got running, expected finished");
        $fatal(1, "[TB] global timeout");
    end

endmodule
